// File: rtl/dmem_access_unit_if.sv
// ----------------------------------------------------------------------------
// dmem_access_unit_if
//   Bundles the core-side request/response handshake and the word-wide
//   Data_memory port of dmem_access_unit.
//
//   Request  : ReqValid, ReqReady, ReqWrite, ReqSize, ReqSigned, ReqAddr,
//              ReqWrData
//   Response : RspValid, RspRdData, RspError
//   Memory   : DmemAddr (word index), DmemWrite, DmemWrData, DmemRdData
//
//   slave  : the access unit itself.
//   master : the environment around it, i.e. the core issuing requests and
//            the Data_memory answering reads, so it also drives DmemRdData.
// ----------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWrData;
  logic        RspValid;
  logic [31:0] RspRdData;
  logic        RspError;
  logic [31:0] DmemAddr;
  logic        DmemWrite;
  logic [31:0] DmemWrData;
  logic [31:0] DmemRdData;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData,
    input  DmemRdData,
    output ReqReady, RspValid, RspRdData, RspError,
    output DmemAddr, DmemWrite, DmemWrData
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWrData,
    output DmemRdData,
    input  ReqReady, RspValid, RspRdData, RspError,
    input  DmemAddr, DmemWrite, DmemWrData
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ----------------------------------------------------------------------------
// dmem_access_unit
//   Load/store unit in front of a word-only Data_memory. Byte-addressed
//   byte/half/word requests are turned into word-indexed accesses; sub-word
//   stores are done as read-modify-write because the memory has only a
//   whole-word write enable. Loads return sign/zero-extended data. Misaligned
//   or illegal-size requests are answered with RspError and never reach memory.
//
//   Ports:
//     Clk    rising-edge clock
//     Rst_n  asynchronous active-low reset
//     bus    dmem_access_unit_if.slave (request, response and memory port)
// ----------------------------------------------------------------------------
module dmem_access_unit (
  input  logic             Clk,
  input  logic             Rst_n,
  dmem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } stateT;

  stateT       state;
  stateT       nextState;

  logic        isWrite;
  logic        isSigned;
  logic        errLatched;
  logic [1:0]  sizeLatched;
  logic [1:0]  laneLatched;
  logic [31:0] wrDataLatched;
  logic [31:0] dmemAddrReg;
  logic [31:0] dmemWrDataReg;
  logic [31:0] rspRdDataReg;

  logic        accept;
  logic        reqErr;
  logic [31:0] shiftedWord;
  logic [31:0] loadData;
  logic [31:0] mergedWord;

  assign accept = (state == IDLE) && bus.ReqValid;

  // Illegal size, or a half/word whose address is not naturally aligned.
  always_comb begin
    reqErr = 1'b0;
    case (bus.ReqSize)
      2'b01:   reqErr = bus.ReqAddr[0];
      2'b10:   reqErr = (bus.ReqAddr[1:0] != 2'b00);
      2'b11:   reqErr = 1'b1;
      default: reqErr = 1'b0;
    endcase
  end

  // State register; reset drops straight to IDLE so DmemWrite falls at once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Errors skip memory entirely. Sub-word stores must read the old word
  // first, so they go through READ just like loads.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (reqErr) begin
            nextState = RESP;
          end else if (!bus.ReqWrite) begin
            nextState = READ;
          end else if (bus.ReqSize == 2'b10) begin
            nextState = WRITE;
          end else begin
            nextState = READ;
          end
        end
      end
      READ:    nextState = isWrite ? WRITE : RESP;
      WRITE:   nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores.
  // Little-endian: byte k sits at [8k+7:8k], half h at [16h+15:16h].
  // Alignment was already enforced, so a half lane always has laneLatched[0]=0.
  always_comb begin
    shiftedWord = bus.DmemRdData >> {laneLatched, 3'b000};
    loadData    = bus.DmemRdData;
    mergedWord  = wrDataLatched;
    case (sizeLatched)
      2'b00: begin
        loadData = {{24{isSigned & shiftedWord[7]}}, shiftedWord[7:0]};
        mergedWord = bus.DmemRdData;
        mergedWord[{laneLatched, 3'b000} +: 8] = wrDataLatched[7:0];
      end
      2'b01: begin
        loadData = {{16{isSigned & shiftedWord[15]}}, shiftedWord[15:0]};
        mergedWord = bus.DmemRdData;
        mergedWord[{laneLatched[1], 4'b0000} +: 16] = wrDataLatched[15:0];
      end
      default: begin
        loadData   = bus.DmemRdData;
        mergedWord = wrDataLatched;
      end
    endcase
  end

  // Request fields are captured at acceptance so the memory address is
  // registered and stable; READ either produces load data or the merged word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      isWrite       <= 1'b0;
      isSigned      <= 1'b0;
      errLatched    <= 1'b0;
      sizeLatched   <= 2'b00;
      laneLatched   <= 2'b00;
      wrDataLatched <= 32'h0;
      dmemAddrReg   <= 32'h0;
      dmemWrDataReg <= 32'h0;
      rspRdDataReg  <= 32'h0;
    end else if (accept) begin
      isWrite       <= bus.ReqWrite;
      isSigned      <= bus.ReqSigned;
      errLatched    <= reqErr;
      sizeLatched   <= bus.ReqSize;
      laneLatched   <= bus.ReqAddr[1:0];
      wrDataLatched <= bus.ReqWrData;
      dmemAddrReg   <= {2'b00, bus.ReqAddr[31:2]};
      if (bus.ReqWrite && (bus.ReqSize == 2'b10) && !reqErr) begin
        dmemWrDataReg <= bus.ReqWrData;
      end
    end else if (state == READ) begin
      if (isWrite) begin
        dmemWrDataReg <= mergedWord;
      end else begin
        rspRdDataReg <= loadData;
      end
    end
  end

  assign bus.ReqReady   = (state == IDLE);
  assign bus.RspValid   = (state == RESP);
  assign bus.RspError   = (state == RESP) && errLatched;
  assign bus.RspRdData  = rspRdDataReg;
  assign bus.DmemAddr   = dmemAddrReg;
  assign bus.DmemWrite  = (state == WRITE);
  assign bus.DmemWrData = dmemWrDataReg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_dmem_access_unit
//   Drives dmem_access_unit through its interface and plays the role of a
//   64-word Data_memory with combinational read and clocked write.
//   Expected response records are queued when a request is driven and
//   popped when the unit answers.
// ----------------------------------------------------------------------------
module tb_dmem_access_unit;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic memInit = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 Clk = ~Clk;

  dmem_access_unit_if bus ();

  dmem_access_unit dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  // Data_memory stand-in: cleared while memInit is high, written on DmemWrite.
  logic [31:0] mem [0:63];
  always @(posedge Clk) begin
    if (memInit) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (bus.DmemWrite) begin
      mem[bus.DmemAddr[5:0]] <= bus.DmemWrData;
    end
  end
  assign bus.DmemRdData = mem[bus.DmemAddr[5:0]];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        expErr;
    logic [31:0] expRd;
    int          expEdge;
    int          expWrites;
    logic [31:0] expWrWord;
  } vecT;

  vecT scoreboard[$];
  vecT vecs[22];

  function automatic vecT makeVec(logic wr, logic [1:0] size, logic sgn,
                                  logic [31:0] addr, logic [31:0] wdata,
                                  logic expErr, logic [31:0] expRd,
                                  int expEdge, int expWrites,
                                  logic [31:0] expWrWord);
    vecT v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.expErr = expErr; v.expRd = expRd; v.expEdge = expEdge;
    v.expWrites = expWrites; v.expWrWord = expWrWord;
    return v;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Waits for an idle unit, presents the request and returns right after
  // the acceptance edge E0.
  task automatic applyStimulus(input vecT v, input bit expectRsp, input string tag);
    int waited = 0;
    @(negedge Clk);
    while (!bus.ReqReady && waited < 10) begin
      @(negedge Clk);
      waited++;
    end
    compareVal({tag, ".readyWait"}, 32'(bus.ReqReady), 32'h1);
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = v.wr;
    bus.ReqSize   = v.size;
    bus.ReqSigned = v.sgn;
    bus.ReqAddr   = v.addr;
    bus.ReqWrData = v.wdata;
    if (expectRsp) scoreboard.push_back(v);
    @(posedge Clk);
  endtask

  // Pops the oldest expectation and compares it with what was observed.
  task automatic checkOutput(input string tag, input int edgeSeen, input int writes,
                             input logic [31:0] wrWord, input logic [31:0] wrAddr,
                             input logic rspErr, input logic [31:0] rspRd,
                             input logic [31:0] addrAtRsp);
    vecT e;
    if (scoreboard.size() == 0) begin
      compareVal({tag, ".scoreboardEmpty"}, 32'h1, 32'h0);
      return;
    end
    e = scoreboard.pop_front();
    compareVal({tag, ".rspEdge"}, 32'(edgeSeen), 32'(e.expEdge));
    compareVal({tag, ".rspError"}, 32'(rspErr), 32'(e.expErr));
    compareVal({tag, ".rspRdData"}, rspRd, e.expRd);
    compareVal({tag, ".writeCycles"}, 32'(writes), 32'(e.expWrites));
    compareVal({tag, ".dmemAddr"}, addrAtRsp, {2'b00, e.addr[31:2]});
    if (e.expWrites > 0) begin
      compareVal({tag, ".dmemWrData"}, wrWord, e.expWrWord);
      compareVal({tag, ".dmemWrAddr"}, wrAddr, {2'b00, e.addr[31:2]});
    end
  endtask

  // Called right at the acceptance edge E0. Samples 1 time unit after each
  // edge; a response seen k samples in closes at edge E(k+1).
  task automatic collectResponse(input string tag);
    int edgeSeen = -1;
    int writes = 0;
    logic [31:0] wrWord = 32'h0;
    logic [31:0] wrAddr = 32'h0;
    logic rspErr = 1'b0;
    logic [31:0] rspRd = 32'h0;
    logic [31:0] addrAtRsp = 32'h0;
    #1;
    compareVal({tag, ".accepted"}, 32'(bus.ReqReady), 32'h0);
    bus.ReqValid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge Clk);
        #1;
      end
      if (bus.DmemWrite) begin
        writes++;
        wrWord = bus.DmemWrData;
        wrAddr = bus.DmemAddr;
      end
      if (bus.RspValid) begin
        edgeSeen  = c + 1;
        rspErr    = bus.RspError;
        rspRd     = bus.RspRdData;
        addrAtRsp = bus.DmemAddr;
        break;
      end
    end
    checkOutput(tag, edgeSeen, writes, wrWord, wrAddr, rspErr, rspRd, addrAtRsp);
  endtask

  task automatic runVector(input vecT v, input string tag);
    applyStimulus(v, 1'b1, tag);
    collectResponse(tag);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecT v;

    //                 wr    size   sgn   addr    wdata         err   expRd         edge wr expWrWord
    vecs[0]  = makeVec(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 1, 32'hDEADBEEF);
    vecs[1]  = makeVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0, 32'h0);
    vecs[2]  = makeVec(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0, 32'hDEADBEEF, 2, 1, 32'h11223344);
    vecs[3]  = makeVec(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 1'b0, 32'hDEADBEEF, 3, 1, 32'h1122A544);
    vecs[4]  = makeVec(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        1'b0, 32'hFFFFFFA5, 2, 0, 32'h0);
    vecs[5]  = makeVec(1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        1'b0, 32'h000000A5, 2, 0, 32'h0);
    vecs[6]  = makeVec(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 1'b0, 32'h000000A5, 3, 1, 32'h8001A544);
    vecs[7]  = makeVec(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        1'b0, 32'hFFFF8001, 2, 0, 32'h0);
    vecs[8]  = makeVec(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        1'b0, 32'h00008001, 2, 0, 32'h0);
    vecs[9]  = makeVec(1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        1'b1, 32'h00008001, 1, 0, 32'h0);
    vecs[10] = makeVec(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 1'b1, 32'h00008001, 1, 0, 32'h0);
    vecs[11] = makeVec(1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        1'b1, 32'h00008001, 1, 0, 32'h0);
    vecs[12] = makeVec(1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        1'b0, 32'h8001A544, 2, 0, 32'h0);
    vecs[13] = makeVec(1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        1'b0, 32'h00000044, 2, 0, 32'h0);
    vecs[14] = makeVec(1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 2, 0, 32'h0);
    vecs[15] = makeVec(1'b0, 2'b01, 1'b1, 32'h10, 32'h0,        1'b0, 32'hFFFFA544, 2, 0, 32'h0);
    vecs[16] = makeVec(1'b1, 2'b00, 1'b1, 32'h13, 32'hFFFFFF7F, 1'b0, 32'hFFFFA544, 3, 1, 32'h7F01A544);
    vecs[17] = makeVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'h7F01A544, 2, 0, 32'h0);
    vecs[18] = makeVec(1'b1, 2'b11, 1'b0, 32'h20, 32'h12345678, 1'b1, 32'h7F01A544, 1, 0, 32'h0);
    vecs[19] = makeVec(1'b1, 2'b01, 1'b0, 32'h20, 32'hCAFEBEEF, 1'b0, 32'h7F01A544, 3, 1, 32'h0000BEEF);
    vecs[20] = makeVec(1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b0, 32'h00000000, 2, 0, 32'h0);
    vecs[21] = makeVec(1'b0, 2'b01, 1'b1, 32'h20, 32'h0,        1'b0, 32'hFFFFBEEF, 2, 0, 32'h0);

    // Reset held with a request pending: nothing may move.
    bus.ReqValid  = 1'b1;
    bus.ReqWrite  = 1'b0;
    bus.ReqSize   = 2'b10;
    bus.ReqSigned = 1'b0;
    bus.ReqAddr   = 32'h10;
    bus.ReqWrData = 32'h0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    compareVal("reset.ReqReady", 32'(bus.ReqReady), 32'h1);
    compareVal("reset.RspValid", 32'(bus.RspValid), 32'h0);
    compareVal("reset.RspError", 32'(bus.RspError), 32'h0);
    compareVal("reset.RspRdData", bus.RspRdData, 32'h0);
    compareVal("reset.DmemAddr", bus.DmemAddr, 32'h0);
    compareVal("reset.DmemWrite", 32'(bus.DmemWrite), 32'h0);
    compareVal("reset.DmemWrData", bus.DmemWrData, 32'h0);

    // Release with ReqValid still high: the very next edge must accept it.
    scoreboard.push_back(makeVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
                                 1'b0, 32'h0, 2, 0, 32'h0));
    memInit = 1'b0;
    Rst_n   = 1'b1;
    @(posedge Clk);
    collectResponse("resetRelease");

    for (int i = 0; i < 22; i++) begin
      runVector(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset arriving during the WRITE cycle of a byte read-modify-write.
    runVector(makeVec(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344,
                      1'b0, 32'hFFFFBEEF, 2, 1, 32'h11223344), "rstPrep");
    v = makeVec(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF,
                1'b0, 32'h0, 3, 1, 32'h112233FF);
    applyStimulus(v, 1'b0, "rstWrite");
    #1;
    bus.ReqValid = 1'b0;
    @(posedge Clk);
    #1;
    compareVal("rstWrite.inWrite", 32'(bus.DmemWrite), 32'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    compareVal("rstWrite.writeDropped", 32'(bus.DmemWrite), 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      compareVal($sformatf("rstWrite.noRsp%0d", c), 32'(bus.RspValid), 32'h0);
      compareVal($sformatf("rstWrite.noWrite%0d", c), 32'(bus.DmemWrite), 32'h0);
    end
    compareVal("rstWrite.ReqReady", 32'(bus.ReqReady), 32'h1);
    compareVal("rstWrite.memKept", mem[4], 32'h11223344);
    Rst_n = 1'b1;
    runVector(makeVec(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,
                      1'b0, 32'h11223344, 2, 0, 32'h0), "rstReadBack");

    repeat (2) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store access unit sitting directly upstream of `Data_memory` in the MIPS datapath. It accepts byte-addressed load/store requests of byte, halfword or word size from the core, translates them into word-indexed `Data_memory` accesses, and performs read-modify-write for sub-word stores, because `Data_memory` has only a whole-word write enable. It returns sign- or zero-extended load data and flags misaligned or illegal requests without touching memory.

## Interface
Parameters: none. Data and address widths are fixed at 32.

Ports:
- `Clk`  in  1  system clock, rising edge
- `Rst_n`  in  1  asynchronous, active-low reset
- `ReqValid`  in  1  request present
- `ReqReady`  out  1  unit idle; request accepted when `ReqValid && ReqReady` at a rising edge
- `ReqWrite`  in  1  1 = store, 0 = load
- `ReqSize`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `ReqSigned`  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- `ReqAddr`  in  32  byte address
- `ReqWrData`  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- `RspValid`  out  1  one-cycle completion pulse
- `RspRdData`  out  32  extended load data; holds until the next load response
- `RspError`  out  1  valid with `RspValid`: misaligned or illegal size
- `DmemAddr`  out  32  word index to `Data_memory`, `{2'b00, addr[31:2]}`
- `DmemWrite`  out  1  word write enable to `Data_memory`
- `DmemWrData`  out  32  merged write word to `Data_memory`
- `DmemRdData`  in  32  combinational read data from `Data_memory` for `DmemAddr`

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `ReqReady`=1. On acceptance, latch all request fields and check them.
  - Error if size=11, half with addr[0]=1, or word with addr[1:0]≠0. Next state is RESP with error=1, and no memory access occurs.
  - Load goes to READ. Word store goes to WRITE. Byte or half store goes to READ.
- READ: `DmemWrite`=0. Sample `DmemRdData` at the closing edge.
  - Load: extract the lane and extend it into `RspRdData`, then go to RESP.
  - Sub-word store: merge the store lane into the sampled word to form `DmemWrData`, then go to WRITE.
- WRITE: `DmemWrite`=1 for exactly this cycle. Memory updates at the closing edge. Go to RESP.
- RESP: `RspValid`=1 and `RspError` = latched error. Go to IDLE.
- Lanes are little-endian. Byte k = addr[1:0] occupies [8k+7:8k]. Half h = addr[1] occupies [16h+15:16h]. Word store writes `ReqWrData` unchanged.
- Extension: lb/lh replicate the lane MSB. lbu/lhu/lw fill with zeros. `ReqSigned` is ignored for word loads and for stores.
- `ReqReady`=0 in READ, WRITE and RESP. `ReqValid` in those states is ignored, not queued.
- `RspRdData` is unchanged by stores and errors.

## Timing
- Acceptance edge E0. `RspValid` is high in the cycle after edge:
  - E1 for an error.
  - E2 for a load or a word store.
  - E3 for a sub-word store.
- Maximum throughput: one request per 3 (load/word store) or 4 (sub-word store) cycles. The next request can be accepted at the edge ending RESP+1, i.e. the first IDLE cycle.
- `DmemAddr` is registered at acceptance and stable through READ, WRITE and RESP. No combinational path exists from `Req*` to `Dmem*`.
- `DmemWrite` is decoded from the state register only, so it is glitch-free.
- Reset values: state IDLE, `ReqReady`=1, `RspValid`=0, `RspError`=0, `RspRdData`=0, `DmemAddr`=0, `DmemWrite`=0, `DmemWrData`=0.
- Reset mid-operation: asserting `Rst_n` asynchronously forces IDLE and drops `DmemWrite` immediately. An in-flight request is discarded with no response. Memory is unmodified unless the WRITE-closing edge preceded reset.
- After `Rst_n` rises, the first request is accepted at the first following edge with `ReqValid`=1.

## Test plan
- Reset: hold `Rst_n`=0 with `ReqValid`=1 -> all outputs at reset values, no `DmemWrite`; release -> request accepted at next edge.
- Word round-trip: sw 0xDEADBEEF at 0x10 -> `DmemAddr`=4, `DmemWrite` high one cycle, `RspValid` at E2. Then lw 0x10 -> `RspRdData`=0xDEADBEEF at E2, `RspError`=0.
- Byte RMW: word 4 = 0x11223344, sb 0xA5 at 0x11 -> READ then WRITE with `DmemWrData`=0x1122A544, `RspValid` at E3. Then lb 0x11 -> 0xFFFFFFA5, and lbu 0x11 -> 0x000000A5.
- Half RMW: sh 0x8001 at 0x12 on 0x1122A544 -> memory 0x8001A544. Then lh 0x12 -> 0xFFFF8001, and lhu 0x12 -> 0x00008001.
- Errors: lw 0x13, sh 0x11, and size=11 at 0x10 -> `RspValid`+`RspError` at E1, `DmemWrite` never asserted, `RspRdData` unchanged.
- Reset during WRITE of sb 0xFF at 0x10 on 0x11223344 -> `DmemWrite` falls with `Rst_n`, no `RspValid`, word 4 still reads 0x11223344, `ReqReady`=1.
